// File: rtl/floating_point_seq_if.sv
// Operand/result bundle between a requester and floating_point_seq.
// The master owns start/op/a/b; the slave returns busy/done and the held result with its flags.
interface floating_point_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         overflow;
   logic         underflow;
   logic         invalid;

   modport master (
      output start, op, a, b,
      input  busy, done, result, overflow, underflow, invalid
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, overflow, underflow, invalid
   );
endinterface

// File: rtl/floating_point_seq.sv
// Multi-cycle FP add/sub/mul, round-to-nearest-even; accept-to-done 4 cycles (add/sub) or MAN_W+4 (mul).
// No backpressure: start is ignored while busy or in FIN; result and flags hold until the next done.
module floating_point_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic clk,
   input logic reset,
   floating_point_seq_if.slave fp
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int AW   = MAN_W + 4;
   localparam int LZW  = $clog2(PW) + 1;
   localparam int XW   = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
   localparam int CW   = $clog2(MAN_W + 2);
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0]    SHMAX = EXP_W'(MAN_W + 3);
   localparam logic signed [XW-1:0] EZERO = '0;
   localparam logic signed [XW-1:0] ETOP  = XW'(EMAX);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, MUL, NORM, ROUND, FIN} stateT;

   stateT                state;
   logic [W-1:0]         aR, bR, specRes;
   logic [1:0]           opR;
   logic                 specV, specInv, effSub, sgn, isZero;
   logic [AW-1:0]        bigAl, smallAl;
   logic signed [XW-1:0] expR;
   logic [PW-1:0]        acc;
   logic [MAN_W:0]       mb;
   logic [CW-1:0]        cnt;

   // Special operands are resolved at accept time and override the datapath at ROUND.
   logic [EXP_W-1:0] inEa, inEb;
   logic             inSbEff, nxtSpec, nxtInv;
   logic [W-1:0]     nxtRes;

   always_comb begin
      inEa    = fp.a[W-2 -: EXP_W];
      inEb    = fp.b[W-2 -: EXP_W];
      inSbEff = fp.b[W-1] ^ (fp.op == 2'b01);
      nxtSpec = 1'b0;
      nxtInv  = 1'b0;
      nxtRes  = '0;
      if (fp.op == 2'b11 || (&inEa) || (&inEb)) begin
         nxtSpec = 1'b1;
         nxtInv  = 1'b1;
         nxtRes  = QNAN;
      end else if (fp.op == 2'b10) begin
         if (inEa == '0 || inEb == '0) begin
            nxtSpec = 1'b1;
            nxtRes  = {fp.a[W-1] ^ fp.b[W-1], {(W-1){1'b0}}};
         end
      end else if (inEa == '0 && inEb == '0) begin
         nxtSpec = 1'b1;
         nxtRes  = {fp.a[W-1] & inSbEff, {(W-1){1'b0}}};
      end else if (inEa == '0) begin
         nxtSpec = 1'b1;
         nxtRes  = {inSbEff, fp.b[W-2:0]};
      end else if (inEb == '0) begin
         nxtSpec = 1'b1;
         nxtRes  = fp.a;
      end
   end

   logic [EXP_W-1:0]       ea, eb, bigE, smallE, diff, sh;
   logic                   sbEff, aBig;
   logic [MAN_W:0]         bigM, smallM;
   logic [2*(MAN_W+3)-1:0] alignTmp;
   logic [AW:0]            sum;

   assign ea       = aR[W-2 -: EXP_W];
   assign eb       = bR[W-2 -: EXP_W];
   assign sbEff    = bR[W-1] ^ (opR == 2'b01);
   assign aBig     = aR[W-2:0] >= bR[W-2:0];
   assign bigE     = aBig ? ea : eb;
   assign smallE   = aBig ? eb : ea;
   assign bigM     = {1'b1, aBig ? aR[MAN_W-1:0] : bR[MAN_W-1:0]};
   assign smallM   = {1'b1, aBig ? bR[MAN_W-1:0] : aR[MAN_W-1:0]};
   assign diff     = bigE - smallE;
   assign sh       = (diff >= SHMAX) ? SHMAX : diff;
   // Upper half is the aligned fraction with guard/round; anything in the lower half is sticky.
   assign alignTmp = {smallM, 2'b00, {(MAN_W+3){1'b0}}} >> sh;
   assign sum      = effSub ? ({1'b0, bigAl} - {1'b0, smallAl}) : ({1'b0, bigAl} + {1'b0, smallAl});

   logic [LZW-1:0] lz;

   always_comb begin
      lz = '0;
      for (int i = 0; i <= PW - 2; i++) begin
         if (acc[i]) lz = LZW'(PW - 2 - i);
      end
   end

   // Normalised layout: leading one at PW-2, then MAN_W fraction bits, guard, round, sticky field.
   logic [MAN_W:0]       mant;
   logic                 gBit, rBit, sBit, rnd, ovf, unf;
   logic [MAN_W+1:0]     mantR;
   logic signed [XW-1:0] expF;
   logic [MAN_W-1:0]     fracF;
   logic [W-1:0]         normRes;

   assign mant    = acc[PW-2 -: MAN_W+1];
   assign gBit    = acc[MAN_W-1];
   assign rBit    = acc[MAN_W-2];
   assign sBit    = |acc[MAN_W-3:0];
   assign rnd     = gBit & (rBit | sBit | mant[0]);
   assign mantR   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd};
   assign expF    = expR + XW'(mantR[MAN_W+1]);
   assign fracF   = mantR[MAN_W+1] ? mantR[MAN_W:1] : mantR[MAN_W-1:0];
   assign unf     = expF <= EZERO;
   assign ovf     = expF >= ETOP;
   assign normRes = ovf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                    unf ? {sgn, {(W-1){1'b0}}} :
                          {sgn, expF[EXP_W-1:0], fracF};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         fp.busy      <= 1'b0;
         fp.done      <= 1'b0;
         fp.result    <= '0;
         fp.overflow  <= 1'b0;
         fp.underflow <= 1'b0;
         fp.invalid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               fp.done <= 1'b0;
               if (fp.start) begin
                  aR           <= fp.a;
                  bR           <= fp.b;
                  opR          <= fp.op;
                  specV        <= nxtSpec;
                  specInv      <= nxtInv;
                  specRes      <= nxtRes;
                  cnt          <= '0;
                  fp.busy      <= 1'b1;
                  fp.overflow  <= 1'b0;
                  fp.underflow <= 1'b0;
                  fp.invalid   <= 1'b0;
                  state        <= (fp.op == 2'b10) ? MUL : ALIGN;
               end
            end
            ALIGN: begin
               bigAl   <= {bigM, 3'b000};
               smallAl <= {alignTmp[2*(MAN_W+3)-1 -: MAN_W+3], |alignTmp[MAN_W+2:0]};
               effSub  <= aR[W-1] ^ sbEff;
               sgn     <= aBig ? aR[W-1] : sbEff;
               expR    <= XW'(bigE);
               state   <= ADD;
            end
            ADD: begin
               acc   <= PW'(sum) << (MAN_W - 3);
               state <= NORM;
            end
            MUL: begin
               // First cycle sets up exponent and clears the product; then one multiplier bit per cycle, MSB first.
               if (cnt == '0) begin
                  acc  <= '0;
                  mb   <= {1'b1, bR[MAN_W-1:0]};
                  expR <= XW'(ea) + XW'(eb) - XW'(BIAS);
                  sgn  <= aR[W-1] ^ bR[W-1];
               end else begin
                  acc <= (acc << 1) + (mb[MAN_W] ? PW'({1'b1, aR[MAN_W-1:0]}) : '0);
                  mb  <= mb << 1;
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(MAN_W + 1)) state <= NORM;
            end
            NORM: begin
               isZero <= (acc == '0);
               if (acc[PW-1]) begin
                  acc  <= {1'b0, acc[PW-1:2], acc[1] | acc[0]};
                  expR <= expR + XW'(1);
               end else begin
                  acc  <= acc << lz;
                  expR <= expR - XW'(lz);
               end
               state <= ROUND;
            end
            ROUND: begin
               fp.done <= 1'b1;
               fp.busy <= 1'b0;
               if (specV) begin
                  fp.result  <= specRes;
                  fp.invalid <= specInv;
               end else if (isZero) begin
                  fp.result <= '0;
               end else begin
                  fp.result    <= normRes;
                  fp.overflow  <= ovf;
                  fp.underflow <= unf;
               end
               state <= FIN;
            end
            FIN: begin
               fp.done <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_floating_point_seq.sv
// Randomised and directed bench for floating_point_seq at single-precision defaults,
// checked against a reference built on real arithmetic plus explicit single-precision rounding.
module tb_floating_point_seq;
   logic        clk = 1'b0;
   logic        reset;
   int          total = 0;
   int          bad = 0;
   logic [31:0] gotRes;
   logic [2:0]  gotFlags;
   int          gotLat;
   logic        accBusy, doneAfter;

   floating_point_seq_if #(.EXP_W(8), .MAN_W(23)) fpIf ();
   floating_point_seq #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .reset(reset), .fp(fpIf));

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic real toReal(input logic [31:0] x);
      logic [10:0] e11;
      if (x[30:23] == 8'h00) return $bitstoreal({x[31], 63'b0});
      e11 = {3'b000, x[30:23]} + 11'd896;
      return $bitstoreal({x[31], e11, x[22:0], 29'b0});
   endfunction

   // Returns {invalid, overflow, underflow, result}.
   function automatic logic [34:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      real         x, y, v;
      logic [63:0] d;
      logic [23:0] top;
      logic [24:0] topR;
      logic        up;
      int          be;
      if (op == 2'b11 || a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, 32'h7FC00000};
      x = toReal(a);
      y = toReal(b);
      case (op)
         2'b00:   v = x + y;
         2'b01:   v = x - y;
         default: v = x * y;
      endcase
      d = $realtobits(v);
      if (d[62:0] == 63'b0) return {3'b000, d[63], 31'b0};
      top  = {1'b1, d[51:29]};
      up   = d[28] && ((d[27:0] != 28'b0) || top[0]);
      topR = {1'b0, top} + {24'b0, up};
      be   = int'(d[62:52]) - 1023 + 127 + int'(topR[24]);
      if (be >= 255) return {3'b010, d[63], 8'hFF, 23'b0};
      if (be <= 0) return {3'b001, d[63], 31'b0};
      return {3'b000, d[63], be[7:0], topR[24] ? topR[23:1] : topR[22:0]};
   endfunction

   function automatic logic [31:0] randOperand();
      logic [7:0] e;
      int         k;
      k = $urandom_range(0, 19);
      if (k == 0)     e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else if (k < 5) e = 8'($urandom_range(1, 254));
      else            e = 8'($urandom_range(117, 137));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int pokeAt);
      int cyc;
      @(negedge clk);
      fpIf.start = 1'b1;
      fpIf.op    = op;
      fpIf.a     = a;
      fpIf.b     = b;
      @(posedge clk);
      #1;
      fpIf.start = 1'b0;
      fpIf.a     = $urandom;
      fpIf.b     = $urandom;
      fpIf.op    = 2'($urandom);
      accBusy    = fpIf.busy;
      cyc        = 0;
      gotLat     = -1;
      while (gotLat < 0 && cyc < 60) begin
         fpIf.start = (cyc == pokeAt);
         @(posedge clk);
         #1;
         cyc++;
         if (fpIf.done) gotLat = cyc;
      end
      fpIf.start = 1'b0;
      gotRes     = fpIf.result;
      gotFlags   = {fpIf.invalid, fpIf.overflow, fpIf.underflow};
      @(posedge clk);
      #1;
      doneAfter = fpIf.done;
   endtask

   task automatic verifyOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] wantRes, input logic [2:0] wantFlags, input int pokeAt);
      runOp(op, a, b, pokeAt);
      checkVal({tag, " result"}, gotRes, wantRes);
      checkVal({tag, " flags"}, gotFlags, wantFlags);
      checkVal({tag, " latency"}, gotLat, (op == 2'b10) ? 27 : 4);
      checkVal({tag, " busyAtAccept"}, accBusy, 1);
      checkVal({tag, " donePulse"}, doneAfter, 0);
   endtask

   logic [1:0]  dOp   [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
   logic [31:0] dA    [8] = '{32'h3F400000, 32'h41FC0000, 32'hC1FC0000, 32'h401FFFFF,
                              32'h40000000, 32'h7F7FFFFF, 32'h40400000, 32'h7F800000};
   logic [31:0] dB    [8] = '{32'h40100000, 32'h40880000, 32'hC0880000, 32'h3FC00001,
                              32'hBFC00000, 32'h40000000, 32'h40400000, 32'h3F800000};
   logic [31:0] dRes  [8] = '{32'h40400000, 32'h41DA0000, 32'hC20F0000, 32'h40800000,
                              32'hC0400000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
   logic [2:0]  dFlag [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [34:0] m;
      logic [1:0]  op;
      logic [31:0] a, b;
      int          doneCnt;

      reset      = 1'b0;
      fpIf.start = 1'b0;
      fpIf.op    = 2'b00;
      fpIf.a     = '0;
      fpIf.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("reset busy", fpIf.busy, 0);
      checkVal("reset done", fpIf.done, 0);
      checkVal("reset result", fpIf.result, 0);
      checkVal("reset flags", {fpIf.invalid, fpIf.overflow, fpIf.underflow}, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++)
         verifyOp($sformatf("dir%0d", i), dOp[i], dA[i], dB[i], dRes[i], dFlag[i], (dOp[i] == 2'b10) ? 12 : 2);

      for (int i = 0; i < 80; i++) begin
         op = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a  = randOperand();
         case ($urandom_range(0, 7))
            0:       b = a;
            1:       b = {~a[31], a[30:0]};
            default: b = randOperand();
         endcase
         m = refModel(op, a, b);
         verifyOp($sformatf("rnd%0d", i), op, a, b, m[31:0], m[34:32],
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1);
      end

      // Abort a multiply during its tenth cycle.
      @(negedge clk);
      fpIf.start = 1'b1;
      fpIf.op    = 2'b10;
      fpIf.a     = 32'h40000000;
      fpIf.b     = 32'hBFC00000;
      @(posedge clk);
      #1;
      fpIf.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkVal("abort busy", fpIf.busy, 0);
      checkVal("abort done", fpIf.done, 0);
      checkVal("abort result", fpIf.result, 0);
      checkVal("abort flags", {fpIf.invalid, fpIf.overflow, fpIf.underflow}, 0);
      @(negedge clk);
      reset   = 1'b1;
      doneCnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (fpIf.done) doneCnt++;
      end
      checkVal("abort noDone", doneCnt, 0);
      verifyOp("postReset", 2'b00, 32'h3F400000, 32'h40100000, 32'h40400000, 3'b000, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/floating_point_seq.md
FLOATING_POINT_SEQ -- requirements
Module: floating_point_seq

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W; defaults give IEEE-754 single.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request operation; accepted only when busy=0.
REQ-006 op  input  2  00 add, 01 sub (a-b), 10 mul, 11 reserved.
REQ-007 a, b  input  W each  operands {sign, exp, frac}.
REQ-008 busy  output  1  high from accept edge until done pulse.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  W  rounded result; valid while done=1, held until next done.
REQ-011 overflow, underflow, invalid  output  1 each  status flags, updated with done, held with result.

Function
REQ-012 FSM states: IDLE, ALIGN, ADD, MUL, NORM, ROUND, FIN; reset state IDLE.
REQ-013 IDLE and start=1: a, b, op captured at that edge; busy=1; next state ALIGN (add/sub) or MUL (mul).
REQ-014 start while busy=1 ignored; captured operands do not change during an operation.
REQ-015 ALIGN: larger-magnitude operand selected; smaller fraction (hidden bit restored) shifted right by exponent difference into guard/round/sticky bits; shift >= MAN_W+3 leaves only sticky.
REQ-016 ADD: sub inverts b sign; equal effective signs add magnitudes, else subtract smaller from larger; result sign = sign of larger magnitude; one cycle.
REQ-017 MUL: sign = sa XOR sb; exponent = ea+eb-bias, bias = 2^(EXP_W-1)-1; significand product by iterative shift-add, one multiplier bit per cycle, exactly MAN_W+1 cycles.
REQ-018 NORM: single-cycle leading-zero count; left-shift with exponent decrement, or right-shift by 1 on carry-out with increment; shifted-out bits folded into sticky.
REQ-019 ROUND: round-to-nearest-even on guard/round/sticky; mantissa carry-out on rounding renormalises and increments exponent in the same cycle.
REQ-020 FIN: done=1 and busy=0 for one cycle, result/flags registered; then IDLE. start sampled in FIN is ignored.
REQ-021 Latency, accept edge to done=1: add/sub 4 cycles; mul MAN_W+4 cycles (27 at defaults).
REQ-022 Exponent field 0 input treated as signed zero (subnormals flushed); zero operand gives exact result, product of zero = signed zero.
REQ-023 Exact cancellation in add/sub gives +0.
REQ-024 Final exponent >= all-ones: result = signed infinity, overflow=1.
REQ-025 Final exponent <= 0: result = signed zero, underflow=1.
REQ-026 Any input with exponent all-ones, or op=11: result = quiet NaN {0, all-ones exp, 1 then zeros}, invalid=1, normal latency for the op (op=11 uses add latency).
REQ-027 Flags clear at each accept edge.

Reset
REQ-028 reset=0 at a rising edge: state IDLE, busy=0, done=0, result=0, all flags 0.
REQ-029 Reset mid-operation aborts it; no done pulse for the aborted operation; start accepted on the first edge with reset=1.

Verification
REQ-030 add 0x3F400000 (0.75) + 0x40000000... use 0x40100000 (2.25) -> result 0x40400000 (3.0), done 4 cycles after accept, flags 0.
REQ-031 sub 0x41FC0000 (31.5) - 0x40880000 (4.25) -> 0x41DA0000 (27.25); add 0xC1FC0000 + 0xC0880000 -> 0xC20F0000 (-35.75).
REQ-032 add 0x401FFFFF + 0x3FC00001 -> 0x40800000 (tie rounds to even, rounding carry renormalises).
REQ-033 mul 0x40000000 (2.0) x 0xBFC00000 (-1.5) -> 0xC0400000, done 27 cycles after accept; start pulsed mid-op ignored.
REQ-034 mul 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow=1; add 0x40400000 - 0x40400000 via sub -> 0x00000000; add with a=0x7F800000 -> 0x7FC00000, invalid=1.
REQ-035 reset=0 during cycle 10 of a mul -> busy=0, done never pulses, result=0; new add accepted afterwards completes correctly.
